// File: rtl/hci_bank_arbiter.sv
// rtl/hci_bank_arbiter.sv - N-requester HCI arbiter onto a single TCDM bank port
// Round-robin or fixed priority selection, stall watchdog, 1-cycle response routing.
module hci_bank_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned BW        = 8,
  parameter int unsigned MAX_STALL = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      policy_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*AW-1:0]       add_i,
  input  logic [N_REQ-1:0]          wen_i,
  input  logic [N_REQ*DW-1:0]       data_i,
  input  logic [N_REQ*(DW/BW)-1:0]  be_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          r_valid_o,
  output logic [DW-1:0]             r_data_o,
  output logic [N_REQ-1:0]          starved_o,
  output logic                      mem_req_o,
  output logic [AW-1:0]             mem_add_o,
  output logic                      mem_wen_o,
  output logic [DW-1:0]             mem_data_o,
  output logic [DW/BW-1:0]          mem_be_o,
  input  logic                      mem_gnt_i,
  input  logic [DW-1:0]             mem_r_data_i
);

  localparam int unsigned BEW = DW / BW;
  localparam int unsigned IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW  = $clog2(MAX_STALL + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STALL);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  logic [IW-1:0]             rr_q, rr_d;
  logic [IW-1:0]             resp_idx_q, resp_idx_d;
  logic                      resp_valid_q, resp_valid_d;
  logic [N_REQ-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]             w;
  logic                      found;
  logic                      any_req;
  logic                      hs;

  assign any_req   = |req_i;
  assign mem_req_o = any_req;
  assign hs        = any_req & mem_gnt_i;
  assign r_data_o  = mem_r_data_i;

  always_comb begin
    starved_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      starved_o[i] = (cnt_q[i] == CNT_MAX) & req_i[i];
    end
  end

  // Descending scans leave the lowest matching index in w.
  always_comb begin
    int idx;
    idx   = 0;
    w     = '0;
    found = 1'b0;
    if (|starved_o) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (starved_o[i]) w = IW'(i);
      end
    end else if (policy_i) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (req_i[i]) w = IW'(i);
      end
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = (int'(rr_q) + k) % int'(N_REQ);
        if (!found && req_i[idx]) begin
          w     = IW'(idx);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_o      = '0;
    mem_add_o  = '0;
    mem_wen_o  = 1'b0;
    mem_data_o = '0;
    mem_be_o   = '0;
    if (any_req) begin
      gnt_o[w]   = mem_gnt_i;
      mem_add_o  = add_i[w*AW +: AW];
      mem_wen_o  = wen_i[w];
      mem_data_o = data_i[w*DW +: DW];
      mem_be_o   = be_i[w*BEW +: BEW];
    end
  end

  always_comb begin
    r_valid_o = '0;
    if (resp_valid_q) r_valid_o[resp_idx_q] = 1'b1;
  end

  always_comb begin
    rr_d         = rr_q;
    resp_valid_d = hs;
    resp_idx_d   = hs ? w : resp_idx_q;
    cnt_d        = '0;
    if (hs && !policy_i) begin
      rr_d = (w == LAST_IDX) ? '0 : w + 1'b1;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (req_i[i] && !gnt_o[i]) begin
        cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + 1'b1;
      end
    end
    // Clear drops any response that would have come out next cycle.
    if (clear_i) begin
      rr_d         = '0;
      resp_valid_d = 1'b0;
      resp_idx_d   = '0;
      cnt_d        = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q         <= '0;
      resp_idx_q   <= '0;
      resp_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      rr_q         <= rr_d;
      resp_idx_q   <= resp_idx_d;
      resp_valid_q <= resp_valid_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hci_bank_arbiter.sv
// tb/tb_hci_bank_arbiter.sv - directed scoreboard bench for hci_bank_arbiter
module tb_hci_bank_arbiter;

  localparam int N = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            clear_i;
  logic            policy_i;
  logic [N-1:0]    req_i;
  logic [N*32-1:0] add_i;
  logic [N-1:0]    wen_i;
  logic [N*32-1:0] data_i;
  logic [N*4-1:0]  be_i;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    r_valid_o;
  logic [31:0]     r_data_o;
  logic [N-1:0]    starved_o;
  logic            mem_req_o;
  logic [31:0]     mem_add_o;
  logic            mem_wen_o;
  logic [31:0]     mem_data_o;
  logic [3:0]      mem_be_o;
  logic            mem_gnt_i;
  logic [31:0]     mem_r_data_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd_next = 32'hBEEF_0000;
  logic [3:0]  qv[$];
  logic [31:0] qd[$];

  hci_bank_arbiter #(.N_REQ(N), .AW(32), .DW(32), .BW(8), .MAX_STALL(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .policy_i(policy_i),
    .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .data_i(data_i), .be_i(be_i),
    .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_data_o(r_data_o), .starved_o(starved_o),
    .mem_req_o(mem_req_o), .mem_add_o(mem_add_o), .mem_wen_o(mem_wen_o),
    .mem_data_o(mem_data_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_r_data_i(mem_r_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the grant for the current inputs, queues the expected response, clocks once,
  // then checks the response slot against the scoreboard head.
  task automatic step(input string tag, input logic [3:0] eg);
    logic [3:0]  ev;
    logic [31:0] ed;
    #1;
    chk({tag, ".gnt"}, 32'(gnt_o), 32'(eg));
    chk({tag, ".mem_req"}, 32'(mem_req_o), 32'(req_i != '0));
    if (eg != '0 && !clear_i) begin
      qv.push_back(eg);
      qd.push_back(rd_next);
      rd_next = rd_next + 1;
    end
    @(posedge clk_i);
    #1;
    if (qv.size() > 0) begin
      ev = qv.pop_front();
      ed = qd.pop_front();
      mem_r_data_i = ed;
      #1;
      chk({tag, ".r_valid"}, 32'(r_valid_o), 32'(ev));
      chk({tag, ".r_data"}, r_data_o, ed);
    end else begin
      mem_r_data_i = 32'h0;
      #1;
      chk({tag, ".r_valid_idle"}, 32'(r_valid_o), 32'h0);
    end
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; policy_i = 1'b0; req_i = '0;
    wen_i = '1; be_i = '1; mem_gnt_i = 1'b0; mem_r_data_i = '0;
    for (int i = 0; i < N; i++) begin
      add_i[i*32 +: 32]  = 32'h1000_0000 + 32'(i * 16);
      data_i[i*32 +: 32] = 32'hD000_0000 + 32'(i);
    end
    #1;
    chk("reset.gnt", 32'(gnt_o), 32'h0);
    chk("reset.r_valid", 32'(r_valid_o), 32'h0);
    chk("reset.mem_req", 32'(mem_req_o), 32'h0);
    chk("reset.starved", 32'(starved_o), 32'h0);
    chk("reset.mem_add", mem_add_o, 32'h0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // round-robin fairness, all requesters, bank always ready
    req_i = 4'b1111; mem_gnt_i = 1'b1;
    #1;
    chk("rr.mem_add0", mem_add_o, 32'h1000_0000);
    for (int k = 0; k < 8; k++) step("rr", 4'b0001 << (k % 4));
    req_i = 4'b1001;
    step("rr_end_ptr0", 4'b0001);

    // requester 2 write, pointer goes to 3, then wrap to 0
    req_i = 4'b0100; wen_i[2] = 1'b0; be_i[11:8] = 4'b0110;
    #1;
    chk("wr.mem_wen", 32'(mem_wen_o), 32'h0);
    chk("wr.mem_be", 32'(mem_be_o), 32'h6);
    chk("wr.mem_data", mem_data_o, 32'hD000_0002);
    chk("wr.mem_add", mem_add_o, 32'h1000_0020);
    step("wr", 4'b0100);
    wen_i[2] = 1'b1; be_i[11:8] = 4'b1111;
    req_i = 4'b0011;
    step("wrap", 4'b0001);
    step("ptr1", 4'b0010);
    req_i = '0;
    step("drain1", 4'b0000);

    // fixed priority with starvation of requester 3
    policy_i = 1'b1; req_i = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("fp.starved_lo", 32'(starved_o), 32'h0);
      step("fp", 4'b0010);
    end
    #1;
    chk("fp.starved3", 32'(starved_o), 32'h8);
    step("fp_force", 4'b1000);
    #1;
    chk("fp.starved_after", 32'(starved_o), 32'h0);
    step("fp_back", 4'b0010);
    req_i = '0;
    step("drain2", 4'b0000);

    // bank stall
    policy_i = 1'b0; req_i = 4'b0001; mem_gnt_i = 1'b0;
    for (int k = 0; k < 3; k++) step("stall", 4'b0000);
    mem_gnt_i = 1'b1; rd_next = 32'hCAFE_0001;
    step("stall_gnt", 4'b0001);
    req_i = '0;
    step("drain3", 4'b0000);

    // clear in the handshake cycle drops the response and resets the pointer
    req_i = 4'b0100;
    step("pre_clr", 4'b0100);
    clear_i = 1'b1;
    step("clr", 4'b0100);
    clear_i = 1'b0; req_i = 4'b1001;
    step("post_clr_ptr0", 4'b0001);
    req_i = '0;
    step("drain4", 4'b0000);

    // asynchronous reset while a response is on the outputs
    req_i = 4'b0100;
    step("pre_rst", 4'b0100);
    rst_ni = 1'b0; req_i = '0;
    #1;
    chk("rst.r_valid", 32'(r_valid_o), 32'h0);
    chk("rst.gnt", 32'(gnt_o), 32'h0);
    chk("rst.mem_req", 32'(mem_req_o), 32'h0);
    chk("rst.starved", 32'(starved_o), 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1; req_i = 4'b1001;
    step("post_rst_ptr0", 4'b0001);
    req_i = '0;
    step("drain5", 4'b0000);

    chk("sb.empty", 32'(qv.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
